// File: rtl/mdu_sequencer.sv
// Multi-cycle HI/LO sequencer for the mult/div unit: fixed-latency mult/div commit,
// single-cycle mthi/mtlo, with the issuing instruction cancellable only at issue.
module mdu_sequencer #(
  parameter int MUL_CYC = 5,
  parameter int DIV_CYC = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  localparam int CNT_MAX = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [31:0]        opa_r, opb_r;
  logic               sgn_r, sgn_s;
  logic [31:0]        hi_r, hi_s, lo_r, lo_s;
  logic               busy_r, done_r;
  logic               accept_s, load_s, commit_s;
  logic [63:0]        mul_s, div_s;

  // 64-bit product; operands sign- or zero-extended so the low 64 bits are exact
  function automatic logic [63:0] mul64(input logic [31:0] x, input logic [31:0] y,
                                        input logic sgn);
    logic [63:0] xe, ye;
    xe = sgn ? {{32{x[31]}}, x} : {32'd0, x};
    ye = sgn ? {{32{y[31]}}, y} : {32'd0, y};
    return xe * ye;
  endfunction

  // Truncating division on magnitudes; returns {remainder, quotient}
  function automatic logic [63:0] div_rq(input logic [31:0] x, input logic [31:0] y,
                                         input logic sgn);
    logic        neg_x, neg_y;
    logic [31:0] mx, my, uq, ur, q, r;
    neg_x = sgn & x[31];
    neg_y = sgn & y[31];
    mx = neg_x ? (32'd0 - x) : x;
    my = neg_y ? (32'd0 - y) : y;
    if (my == 32'd0) begin
      uq = 32'd0;
      ur = 32'd0;
    end else begin
      uq = mx / my;
      ur = mx % my;
    end
    q = (neg_x ^ neg_y) ? (32'd0 - uq) : uq;
    r = neg_x ? (32'd0 - ur) : ur;
    return {r, q};
  endfunction

  assign mul_s = mul64(opa_r, opb_r, sgn_r);
  assign div_s = div_rq(opa_r, opb_r, sgn_r);

  // Next-state, counter, shadow-load and HI/LO update logic
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    sgn_s    = sgn_r;
    hi_s     = hi_r;
    lo_s     = lo_r;
    load_s   = 1'b0;
    commit_s = 1'b0;
    accept_s = start && !cancel && (state_r == IDLE) &&
               (op >= 3'd1) && (op <= 3'd6);
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          case (op)
            3'd1, 3'd2: begin
              state_s = MUL;
              cnt_s   = CNT_W'(MUL_CYC);
              load_s  = 1'b1;
              sgn_s   = (op == 3'd1);
            end
            3'd3, 3'd4: begin
              state_s = DIV;
              cnt_s   = CNT_W'(DIV_CYC);
              load_s  = 1'b1;
              sgn_s   = (op == 3'd3);
            end
            3'd5:    hi_s = a;
            3'd6:    lo_s = a;
            default: state_s = IDLE;
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      MUL, DIV: begin
        if (cnt_r <= CNT_W'(1)) begin
          state_s  = IDLE;
          cnt_s    = {CNT_W{1'b0}};
          commit_s = 1'b1;
          if (state_r == MUL) begin
            {hi_s, lo_s} = mul_s;
          end else if (opb_r != 32'd0) begin
            {hi_s, lo_s} = div_s;
          end else begin
            hi_s = hi_r;
          end
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, shadow operands and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      opa_r   <= 32'd0;
      opb_r   <= 32'd0;
      sgn_r   <= 1'b0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      sgn_r   <= sgn_s;
      hi_r    <= hi_s;
      lo_r    <= lo_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= commit_s;
      if (load_s) begin
        opa_r <= a;
        opb_r <= b;
      end else begin
        opa_r <= opa_r;
        opb_r <= opb_r;
      end
    end
  end

  assign hi   = hi_r;
  assign lo   = lo_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed vector table, hand-written corner
// sequences and randomized ops checked against an arithmetic reference model.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        cancel = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_hi = 32'd0, model_lo = 32'd0;
  logic [31:0] pre_hi, pre_lo;

  mdu_sequencer #(.MUL_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bit          keep;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
    logic        exp_done;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: architectural effect of one accepted op, from plain 64-bit arithmetic
  task automatic ref_exec(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int cyc, output logic dn);
    longint sq, sr;
    logic [63:0] p;
    cyc = 0;
    dn  = 1'b0;
    case (o)
      3'd1: begin
        sq = longint'($signed(x)) * longint'($signed(y));
        p = sq;
        {model_hi, model_lo} = p;
        cyc = 5; dn = 1'b1;
      end
      3'd2: begin
        p = {32'd0, x} * {32'd0, y};
        {model_hi, model_lo} = p;
        cyc = 5; dn = 1'b1;
      end
      3'd3: begin
        if (y != 32'd0) begin
          sq = longint'($signed(x)) / longint'($signed(y));
          sr = longint'($signed(x)) % longint'($signed(y));
          model_lo = sq[31:0];
          model_hi = sr[31:0];
        end
        cyc = 10; dn = 1'b1;
      end
      3'd4: begin
        if (y != 32'd0) begin
          model_lo = x / y;
          model_hi = x % y;
        end
        cyc = 10; dn = 1'b1;
      end
      3'd5: model_hi = x;
      3'd6: model_lo = x;
      default: cyc = 0;
    endcase
  endtask

  // Caller is at a negedge; drives one issue cycle and returns at the next negedge
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    pre_hi = hi;
    pre_lo = lo;
    start = 1'b1; op = o; a = x; b = y; cancel = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles while scrambling inputs, then checks the commit cycle
  task automatic finish(input string name, input int exp_cyc, input logic exp_done,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int cancel_at);
    int n = 0;
    logic stable_bad = 1'b0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (hi !== pre_hi || lo !== pre_lo || done !== 1'b0) stable_bad = 1'b1;
      cancel = (n == cancel_at);
      start = 1'($urandom_range(0, 1));
      op = 3'($urandom);
      a = $urandom;
      b = $urandom;
      @(negedge clk);
    end
    start = 1'b0;
    cancel = 1'b0;
    chk({name, ".cycles"}, 32'(n), 32'(exp_cyc));
    chk({name, ".done"}, 32'(done), 32'(exp_done));
    chk({name, ".hi"}, hi, exp_hi);
    chk({name, ".lo"}, lo, exp_lo);
    if (exp_cyc > 0) chk({name, ".stable"}, 32'(stable_bad), 32'd0);
  endtask

  initial begin
    int cyc;
    logic dn;
    logic flag;
    logic [2:0] ro;
    logic [31:0] ra, rb;

    tbl[0]  = '{3'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5, 1'b1};
    tbl[1]  = '{3'd2, 32'hFFFFFFFE, 32'd3, 1'b0, 32'h00000002, 32'hFFFFFFFA, 5, 1'b1};
    tbl[2]  = '{3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b1};
    tbl[3]  = '{3'd4, 32'd7, 32'd0, 1'b1, 32'd0, 32'd0, 10, 1'b1};
    tbl[4]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000, 10, 1'b1};
    tbl[5]  = '{3'd5, 32'h12345678, 32'd9, 1'b0, 32'h12345678, 32'h80000000, 0, 1'b0};
    tbl[6]  = '{3'd6, 32'h9ABCDEF0, 32'd9, 1'b0, 32'h12345678, 32'h9ABCDEF0, 0, 1'b0};
    tbl[7]  = '{3'd4, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 10, 1'b1};
    tbl[8]  = '{3'd3, 32'd7, 32'hFFFFFFFE, 1'b0, 32'd1, 32'hFFFFFFFD, 10, 1'b1};
    tbl[9]  = '{3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 32'h3FFFFFFF, 32'h00000001, 5, 1'b1};
    tbl[10] = '{3'd0, 32'h55555555, 32'd1, 1'b1, 32'd0, 32'd0, 0, 1'b0};
    tbl[11] = '{3'd7, 32'h55555555, 32'd1, 1'b1, 32'd0, 32'd0, 0, 1'b0};
    tbl[12] = '{3'd3, 32'd0, 32'd0, 1'b1, 32'd0, 32'd0, 10, 1'b1};

    repeat (3) @(negedge clk);
    chk("reset.hi", hi, 32'd0);
    chk("reset.lo", lo, 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      logic [31:0] eh, el;
      eh = tbl[i].keep ? model_hi : tbl[i].exp_hi;
      el = tbl[i].keep ? model_lo : tbl[i].exp_lo;
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      finish($sformatf("vec%0d", i), tbl[i].exp_cyc, tbl[i].exp_done, eh, el, 0);
      model_hi = eh;
      model_lo = el;
      @(negedge clk);
    end

    // Cancel at issue: nothing accepted
    start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd6; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("cancel_issue.busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("cancel_issue.busy2", 32'(busy), 32'd0);
    chk("cancel_issue.hi", hi, model_hi);
    chk("cancel_issue.lo", lo, model_lo);

    // Cancel during the third busy cycle has no effect
    issue(3'd1, 32'hFFFFFFFE, 32'd3);
    finish("cancel_busy", 5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA, 3);

    // Back-to-back mult issued in the done cycle
    issue(3'd2, 32'd3, 32'd3);
    ref_exec(3'd1, 32'hFFFFFFFF, 32'h00000010, cyc, dn);
    model_hi = 32'd0;
    model_lo = 32'd9;
    finish("b2b_first", 5, 1'b1, 32'd0, 32'd9, 0);
    issue(3'd1, 32'hFFFFFFFF, 32'h00000010);
    finish("b2b_second", 5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF0, 0);
    @(negedge clk);

    // mthi then mtlo on consecutive cycles
    flag = 1'b0;
    start = 1'b1; op = 3'd5; a = 32'h12345678;
    @(negedge clk);
    flag = flag | busy;
    op = 3'd6; a = 32'h9ABCDEF0;
    @(negedge clk);
    flag = flag | busy;
    start = 1'b0;
    @(negedge clk);
    flag = flag | busy;
    chk("mthi_mtlo.hi", hi, 32'h12345678);
    chk("mthi_mtlo.lo", lo, 32'h9ABCDEF0);
    chk("mthi_mtlo.busy", 32'(flag), 32'd0);
    model_hi = 32'h12345678;
    model_lo = 32'h9ABCDEF0;

    // Reset asserted in the fourth busy cycle of a div
    issue(3'd3, 32'd100, 32'd3);
    repeat (3) @(negedge clk);
    chk("rst_mid.busy_before", 32'(busy), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("rst_mid.busy", 32'(busy), 32'd0);
    chk("rst_mid.hi", hi, 32'd0);
    chk("rst_mid.lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      flag = flag | done | busy;
    end
    chk("rst_mid.no_done", 32'(flag), 32'd0);
    chk("rst_mid.hi_after", hi, 32'd0);
    model_hi = 32'd0;
    model_lo = 32'd0;

    // Randomized ops against the reference model
    for (int i = 0; i < 50; i++) begin
      ro = ($urandom_range(0, 9) == 0) ? 3'(7 * $urandom_range(0, 1)) : 3'($urandom_range(1, 6));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      issue(ro, ra, rb);
      ref_exec(ro, ra, rb, cyc, dn);
      finish($sformatf("rnd%0d_op%0d", i, ro), cyc, dn, model_hi, model_lo,
             int'($urandom_range(0, 6)));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 SHALL have parameter MUL_CYC, default 5, meaning busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYC, default 10, meaning busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  E-stage issue strobe for an MDU instruction.
REQ-006 SHALL have port op  input  3  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-007 SHALL have port a  input  32  forwarded rs operand.
REQ-008 SHALL have port b  input  32  forwarded rt operand.
REQ-009 SHALL have port cancel  input  1  interrupt/exception flush of the issuing instruction (IntReq).
REQ-010 SHALL have port hi  output  32  architectural HI register.
REQ-011 SHALL have port lo  output  32  architectural LO register.
REQ-012 SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse in the cycle HI/LO are committed by mult/div.

Function
REQ-014 SHALL implement states IDLE, MUL, DIV; busy=1 exactly in MUL or DIV.
REQ-015 SHALL accept an issue when start=1, cancel=0, state IDLE, op in 1..6.
REQ-016 SHALL, on accepted op 1/2, latch a,b into shadow operands, load counter with MUL_CYC, enter MUL at the next edge.
REQ-017 SHALL, on accepted op 3/4, latch operands, load counter with DIV_CYC, enter DIV at the next edge.
REQ-018 SHALL decrement the counter each cycle in MUL/DIV; at the edge where counter reaches 0 commit result to hi/lo, pulse done=1 for the following cycle, return to IDLE.
REQ-019 SHALL hold busy=1 for exactly MUL_CYC (resp. DIV_CYC) consecutive cycles starting the cycle after the accepted start.
REQ-020 SHALL compute mult as signed 32x32->64 {hi,lo}; multu unsigned.
REQ-021 SHALL compute div/divu lo=quotient, hi=remainder; signed remainder takes dividend sign (truncating division).
REQ-022 SHALL, for signed 0x80000000 / 0xFFFFFFFF, commit lo=0x80000000, hi=0x00000000.
REQ-023 SHALL, for divisor 0, still run DIV_CYC busy cycles and leave hi/lo unchanged; done still pulses.
REQ-024 SHALL, on accepted op 5 (mthi), write hi=a at the next edge, no busy, no done; op 6 (mtlo) writes lo=a likewise.
REQ-025 SHALL ignore start when cancel=1 in the same cycle (no state, hi, lo change).
REQ-026 SHALL ignore start while busy=1 (including mthi/mtlo); upstream stall guarantees none arrive.
REQ-027 SHALL let cancel asserted during MUL/DIV have no effect; started operation completes and commits.
REQ-028 SHALL keep hi/lo stable during MUL/DIV; shadow operands, not a/b, determine the result.
REQ-029 SHALL accept a new start in the same cycle done=1 (state already IDLE).
REQ-030 SHALL implement the datapath as fixed-latency: result may be produced combinationally or iteratively, but commit timing per REQ-018 is exact.

Reset
REQ-031 SHALL, when reset=0, asynchronously force state IDLE, counter 0, hi=0, lo=0, busy=0, done=0, shadow operands 0.
REQ-032 SHALL abort any in-flight operation on reset with no commit; first accepted start after reset release behaves per REQ-015.

Verification
REQ-033 SHALL cover: mult a=0xFFFFFFFE, b=3 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done 1 cycle; multu same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-034 SHALL cover: div a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=7, b=0 -> busy 10 cycles, hi/lo unchanged.
REQ-035 SHALL cover: start=1, op=1, cancel=1 -> busy stays 0, hi/lo unchanged; cancel=1 in 3rd busy cycle of mult -> result still committed on schedule.
REQ-036 SHALL cover: mthi a=0x12345678 then mtlo a=0x9ABCDEF0 on consecutive cycles -> hi=0x12345678, lo=0x9ABCDEF0, busy never 1.
REQ-037 SHALL cover: reset=0 asserted mid-div (cycle 4) -> immediate busy=0, hi=lo=0; no done pulse after release.
REQ-038 SHALL cover: start during busy with changed a/b -> ignored, committed result matches original operands; back-to-back mult issued in done cycle -> second busy window starts next cycle.
